// File: rtl/qspi_rom_fetch.sv
// Single-byte cartridge ROM fetch over quad SPI (Fast Read Quad I/O, 0xEB).
// A one-entry last-address buffer answers repeated fetches without touching the flash.
module qspi_rom_fetch #(
  parameter int          ADDR_W       = 12,
  parameter logic [23:0] ROM_BASE     = 24'h100000,
  parameter int          DESEL_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              valid,
  output logic [7:0]        data,
  output logic              sclk,
  output logic              select_n,
  output logic [3:0]        io_out,
  output logic [3:0]        io_oe,
  input  logic [3:0]        io_in
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA, S_DESEL
  } state_t;

  localparam logic [7:0] CMD_QUAD_READ = 8'hEB;
  localparam logic [7:0] DESEL_LAST    = 8'(DESEL_CYCLES - 1);

  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic        half, half_n;      // 0: SCK low half, 1: SCK high half
  logic [23:0] faddr, faddr_n;
  logic [3:0]  rx, rx_n;
  logic [23:0] tag, tag_n;
  logic        tag_ok, tag_ok_n;
  logic        busy_n, valid_n, sclk_n, select_n_n;
  logic [7:0]  data_n;
  logic [3:0]  io_out_n, io_oe_n;
  logic [23:0] req_faddr;
  logic [7:0]  cnt_inc;

  function automatic logic cmd_bit(input logic [7:0] idx);
    logic [7:0] s;
    s = CMD_QUAD_READ << idx;
    return s[7];
  endfunction

  function automatic logic [3:0] addr_nibble(input logic [23:0] a, input logic [7:0] idx);
    logic [23:0] s;
    s = a << {idx, 2'b00};
    return s[23:20];
  endfunction

  // NOTE: every variable gets a default before the case, so no path leaves one unassigned (no latches).
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    half_n     = half;
    faddr_n    = faddr;
    rx_n       = rx;
    tag_n      = tag;
    tag_ok_n   = tag_ok;
    busy_n     = busy;
    valid_n    = 1'b0;
    data_n     = data;
    sclk_n     = sclk;
    select_n_n = select_n;
    io_out_n   = io_out;
    io_oe_n    = io_oe;
    req_faddr  = ROM_BASE + 24'(addr);
    cnt_inc    = cnt + 8'd1;

    unique case (state)
      S_IDLE: begin
        if (req) begin
          if (tag_ok && (req_faddr == tag)) begin
            valid_n = 1'b1;
          end else begin
            faddr_n    = req_faddr;
            state_n    = S_CMD;
            cnt_n      = 8'd0;
            half_n     = 1'b0;
            select_n_n = 1'b0;
            busy_n     = 1'b1;
            io_oe_n    = 4'b0001;
            io_out_n   = {3'b000, CMD_QUAD_READ[7]};
          end
        end
      end

      S_DESEL: begin
        if (cnt == DESEL_LAST) begin
          state_n = S_IDLE;
          busy_n  = 1'b0;
          cnt_n   = 8'd0;
        end else begin
          cnt_n = cnt_inc;
        end
      end

      default: begin
        if (!half) begin
          half_n = 1'b1;
          sclk_n = 1'b1;
        end else begin
          // End of an SCK period: sample, advance, and set up the next low half.
          half_n = 1'b0;
          sclk_n = 1'b0;
          cnt_n  = cnt_inc;
          unique case (state)
            S_CMD: begin
              if (cnt == 8'd7) begin
                state_n  = S_ADDR;
                cnt_n    = 8'd0;
                io_oe_n  = 4'b1111;
                io_out_n = faddr[23:20];
              end else begin
                io_out_n = {3'b000, cmd_bit(cnt_inc)};
              end
            end
            S_ADDR: begin
              if (cnt == 8'd5) begin
                state_n  = S_MODE;
                cnt_n    = 8'd0;
                io_out_n = 4'b0000;
              end else begin
                io_out_n = addr_nibble(faddr, cnt_inc);
              end
            end
            S_MODE: begin
              if (cnt == 8'd1) begin
                state_n  = S_DUMMY;
                cnt_n    = 8'd0;
                io_oe_n  = 4'b0000;
                io_out_n = 4'b0000;
              end
            end
            S_DUMMY: begin
              if (cnt == 8'd3) begin
                state_n = S_DATA;
                cnt_n   = 8'd0;
              end
            end
            S_DATA: begin
              if (cnt == 8'd0) begin
                rx_n = io_in;
              end else begin
                data_n     = {rx, io_in};
                valid_n    = 1'b1;
                select_n_n = 1'b1;
                io_oe_n    = 4'b0000;
                io_out_n   = 4'b0000;
                tag_n      = faddr;
                tag_ok_n   = 1'b1;
                state_n    = S_DESEL;
                cnt_n      = 8'd0;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= 8'd0;
      half     <= 1'b0;
      faddr    <= 24'd0;
      rx       <= 4'd0;
      tag      <= 24'd0;
      tag_ok   <= 1'b0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      data     <= 8'h00;
      sclk     <= 1'b0;
      select_n <= 1'b1;
      io_out   <= 4'd0;
      io_oe    <= 4'd0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      half     <= half_n;
      faddr    <= faddr_n;
      rx       <= rx_n;
      tag      <= tag_n;
      tag_ok   <= tag_ok_n;
      busy     <= busy_n;
      valid    <= valid_n;
      data     <= data_n;
      sclk     <= sclk_n;
      select_n <= select_n_n;
      io_out   <= io_out_n;
      io_oe    <= io_oe_n;
    end
  end

endmodule

// File: tb/tb_qspi_rom_fetch.sv
// Self-checking bench for qspi_rom_fetch: behavioural quad-SPI flash model plus
// a last-address buffer reference; a second instance exercises flash address wrap.
module tb_qspi_rom_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic [11:0] addr = 12'h000;
  logic [3:0]  io_in = 4'h0;
  logic        use_wrap = 1'b0;

  logic        busy, valid, sclk, select_n;
  logic [7:0]  data;
  logic [3:0]  io_out, io_oe;
  logic        w_busy, w_valid, w_sclk, w_select_n;
  logic [7:0]  w_data;
  logic [3:0]  w_io_out, w_io_oe;

  logic req_main, req_wrap;
  assign req_main = req & ~use_wrap;
  assign req_wrap = req & use_wrap;

  always #5 clk = ~clk;

  qspi_rom_fetch u_dut (
    .clk(clk), .reset(reset), .req(req_main), .addr(addr),
    .busy(busy), .valid(valid), .data(data),
    .sclk(sclk), .select_n(select_n), .io_out(io_out), .io_oe(io_oe), .io_in(io_in)
  );

  qspi_rom_fetch #(.ROM_BASE(24'hFFFFFF)) u_wrap (
    .clk(clk), .reset(reset), .req(req_wrap), .addr(addr),
    .busy(w_busy), .valid(w_valid), .data(w_data),
    .sclk(w_sclk), .select_n(w_select_n), .io_out(w_io_out), .io_oe(w_io_oe), .io_in(io_in)
  );

  // Observed pins of whichever instance is under test.
  logic       o_busy, o_valid, o_sclk, o_sel;
  logic [7:0] o_data;
  logic [3:0] o_out, o_oe;
  assign o_busy  = use_wrap ? w_busy     : busy;
  assign o_valid = use_wrap ? w_valid    : valid;
  assign o_sclk  = use_wrap ? w_sclk     : sclk;
  assign o_sel   = use_wrap ? w_select_n : select_n;
  assign o_data  = use_wrap ? w_data     : data;
  assign o_out   = use_wrap ? w_io_out   : io_out;
  assign o_oe    = use_wrap ? w_io_oe    : io_oe;

  function automatic logic [7:0] rom_of(input logic [23:0] a);
    if (a == 24'h100000) return 8'hA5;
    if (a == 24'h000000) return 8'h3C;
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  // Flash model: counts SCK rising edges per select, decodes cmd/addr/mode, drives data.
  int          m_edges = 0;
  int          m_txn = 0;
  logic [7:0]  m_cmd = 8'h00;
  logic [23:0] m_addr = 24'h0;
  logic [7:0]  m_mode = 8'hFF;
  logic [7:0]  m_byte;

  always @(negedge o_sel) begin
    m_edges = 0;
    m_cmd   = 8'h00;
    m_addr  = 24'h0;
    m_mode  = 8'hFF;
    m_txn++;
  end

  always @(posedge o_sclk) begin
    if (o_sel === 1'b0) begin
      m_edges++;
      if (m_edges <= 8)       m_cmd  = {m_cmd[6:0], o_out[0]};
      else if (m_edges <= 14) m_addr = {m_addr[19:0], o_out};
      else if (m_edges <= 16) m_mode = {m_mode[3:0], o_out};
    end
  end

  always @(negedge o_sclk) begin
    if (o_sel === 1'b0) begin
      m_byte = rom_of(m_addr);
      if (m_edges == 20)      io_in = m_byte[7:4];
      else if (m_edges == 21) io_in = m_byte[3:0];
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-run observations; cycle k is the clock period after edge k-1 (edge 0 samples req).
  int         r_first_valid, r_nvalid, r_last_cs_low, r_first_busy_low, r_toggles;
  logic [7:0] r_data;
  logic [3:0] r_oe [0:60];
  logic       r_cs [0:60];

  task automatic run(input logic [11:0] a, input int poke_at, input logic [11:0] poke_addr,
                     input int reset_at);
    logic prev_sclk;
    @(negedge clk);
    addr = a;
    req  = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    r_first_valid = 0; r_nvalid = 0; r_last_cs_low = 0; r_first_busy_low = 0;
    r_toggles = 0; r_data = 8'h00;
    prev_sclk = o_sclk;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (o_valid === 1'b1) begin
        r_nvalid++;
        if (r_first_valid == 0) r_first_valid = k;
        r_data = o_data;
      end
      if (o_sel === 1'b0) r_last_cs_low = k;
      if (o_busy === 1'b0 && r_first_busy_low == 0) r_first_busy_low = k;
      if (o_sclk !== prev_sclk) r_toggles++;
      prev_sclk = o_sclk;
      r_oe[k] = o_oe;
      r_cs[k] = o_sel;
      if (k == poke_at) begin addr = poke_addr; req = 1'b1; end
      else if (k == poke_at + 1) req = 1'b0;
      if (k == reset_at) reset = 1'b1;
      else if (k == reset_at + 1) reset = 1'b0;
    end
  endtask

  // Checks for a full miss transaction against the flash model.
  task automatic check_miss(input string tag, input logic [23:0] fa, input int txn_before);
    check({tag, "_txn"}, 32'(m_txn - txn_before), 32'd1);
    check({tag, "_cmd"}, 32'(m_cmd), 32'hEB);
    check({tag, "_addr"}, 32'(m_addr), 32'(fa));
    check({tag, "_mode"}, 32'(m_mode), 32'h00);
    check({tag, "_valid_cycle"}, 32'(r_first_valid), 32'd45);
    check({tag, "_valid_count"}, 32'(r_nvalid), 32'd1);
    check({tag, "_cs_last_low"}, 32'(r_last_cs_low), 32'd44);
    check({tag, "_busy_low"}, 32'(r_first_busy_low), 32'd47);
    check({tag, "_data"}, 32'(r_data), 32'(rom_of(fa)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          t0;
    logic        ref_ok;
    logic [11:0] ref_a;

    // Reset held for three cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_select_n", 32'(select_n), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_io_oe", 32'(io_oe), 32'd0);
    check("rst_io_out", 32'(io_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_wrap_select_n", 32'(w_select_n), 32'd1);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Miss at 0x000.
    t0 = m_txn;
    run(12'h000, -1, 12'h000, -1);
    check_miss("miss0", 24'h100000, t0);
    check("miss0_oe_cmd", 32'(r_oe[1]), 32'h1);
    check("miss0_oe_addr", 32'(r_oe[17]), 32'hF);
    check("miss0_oe_mode", 32'(r_oe[29]), 32'hF);
    check("miss0_oe_dummy", 32'(r_oe[33]), 32'h0);
    check("miss0_oe_after", 32'(r_oe[45]), 32'h0);
    check("miss0_cs_cycle1", 32'(r_cs[1]), 32'd0);

    // Hit on the same address.
    t0 = m_txn;
    run(12'h000, -1, 12'h000, -1);
    check("hit_valid_cycle", 32'(r_first_valid), 32'd1);
    check("hit_valid_count", 32'(r_nvalid), 32'd1);
    check("hit_data", 32'(r_data), 32'hA5);
    check("hit_cs_never_low", 32'(r_last_cs_low), 32'd0);
    check("hit_sclk_toggles", 32'(r_toggles), 32'd0);
    check("hit_busy", 32'(r_first_busy_low), 32'd1);
    check("hit_txn", 32'(m_txn - t0), 32'd0);

    // Request while busy is ignored.
    t0 = m_txn;
    run(12'h456, 10, 12'h123, -1);
    check_miss("busy", 24'h100456, t0);

    // Reset mid-fetch aborts and invalidates the buffer.
    t0 = m_txn;
    run(12'h789, -1, 12'h000, 20);
    check("rstmid_select_n_21", 32'(r_cs[21]), 32'd1);
    check("rstmid_io_oe_21", 32'(r_oe[21]), 32'h0);
    check("rstmid_no_valid", 32'(r_nvalid), 32'd0);
    check("rstmid_busy_low", 32'(r_first_busy_low), 32'd21);
    t0 = m_txn;
    run(12'h789, -1, 12'h000, -1);
    check_miss("refetch", 24'h100789, t0);
    t0 = m_txn;
    run(12'h456, -1, 12'h000, -1);
    check_miss("after_rst_456", 24'h100456, t0);

    // Flash address wrap on the second instance.
    use_wrap = 1'b1;
    t0 = m_txn;
    run(12'h001, -1, 12'h000, -1);
    check_miss("wrap", 24'h000000, t0);
    use_wrap = 1'b0;
    @(negedge clk);

    // Random fetches against the buffer reference model.
    ref_ok = 1'b1;
    ref_a  = 12'h456;
    for (int i = 0; i < 10; i++) begin
      logic [11:0] a;
      logic [23:0] fa;
      if ($urandom_range(0, 2) == 0) a = ref_a;
      else a = 12'($urandom);
      fa = 24'((32'h100000 + 32'(a)) % 32'h1000000);
      t0 = m_txn;
      run(a, -1, 12'h000, -1);
      if (ref_ok && a == ref_a) begin
        check("rnd_hit_cycle", 32'(r_first_valid), 32'd1);
        check("rnd_hit_data", 32'(r_data), 32'(rom_of(fa)));
        check("rnd_hit_txn", 32'(m_txn - t0), 32'd0);
      end else begin
        check_miss("rnd_miss", fa, t0);
      end
      ref_ok = 1'b1;
      ref_a  = a;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
